// File: rtl/vertex_collector.sv
// vertex_collector: gathers a scalar x,y,z,w component stream into whole vertices held in a FIFO.
// Latency: a vertex appears on out_* one cycle after its w component is captured (fall-through FIFO).
// Backpressure: none toward the source; a vertex completed into a full FIFO is dropped and overflow latches.

// Generic first-word fall-through FIFO; a push into a full FIFO is allowed only when a pop shares the edge.
module vc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push_vld,
  input  logic [W-1:0]             push_dat,
  output logic                     push_rdy,
  output logic                     pop_vld,
  output logic [W-1:0]             pop_dat,
  input  logic                     pop_rdy,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Separate level counter keeps full (DEPTH) and empty (0) distinct while pointers wrap modulo DEPTH.
  assign pop_vld  = (level != '0);
  assign pop      = pop_vld && pop_rdy && !clear;
  assign push_rdy = (level != FULL) || pop;
  assign push     = push_vld && push_rdy && !clear;
  // Zero the data when nothing is stored so stale storage never leaks out.
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

  // Storage is written only on an accepted push; contents need no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + (AW+1)'(1);
      else if (pop && !push) level <= level - (AW+1)'(1);
    end
  end
endmodule

module vertex_collector #(
  parameter int M     = 11,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic signed [M-1:0]    in_component,
  input  logic                   in_component_valid,
  input  logic                   clear,
  output logic signed [M-1:0]    out_x,
  output logic signed [M-1:0]    out_y,
  output logic signed [M-1:0]    out_z,
  output logic signed [M-1:0]    out_w,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic [15:0]            vertex_count
);
  typedef struct packed {
    logic signed [M-1:0] x;
    logic signed [M-1:0] y;
    logic signed [M-1:0] z;
    logic signed [M-1:0] w;
  } vertex_t;

  logic [1:0]          index;
  logic signed [M-1:0] asm_x;
  logic signed [M-1:0] asm_y;
  logic signed [M-1:0] asm_z;
  logic                complete;
  logic                push_rdy;
  vertex_t             push_dat;
  vertex_t             head;

  // The w component completes the vertex directly, without passing through an assembly register.
  assign complete = in_component_valid && !clear && (index == 2'd3);
  assign push_dat = {asm_x, asm_y, asm_z, in_component};

  vc_fifo #(
    .W     ($bits(vertex_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .push_vld (complete),
    .push_dat (push_dat),
    .push_rdy (push_rdy),
    .pop_vld  (out_valid),
    .pop_dat  (head),
    .pop_rdy  (out_ready),
    .level    (level)
  );

  assign out_x = head.x;
  assign out_y = head.y;
  assign out_z = head.z;
  assign out_w = head.w;

  // Component index and x/y/z assembly; index wraps after w whether or not the vertex is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      index <= '0;
      asm_x <= '0;
      asm_y <= '0;
      asm_z <= '0;
    end else if (clear) begin
      index <= '0;
      asm_x <= '0;
      asm_y <= '0;
      asm_z <= '0;
    end else if (in_component_valid) begin
      case (index)
        2'd0:    asm_x <= in_component;
        2'd1:    asm_y <= in_component;
        2'd2:    asm_z <= in_component;
        default: ;
      endcase
      index <= index + 2'd1;
    end
  end

  // Accepted-vertex counter and sticky drop flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow     <= 1'b0;
      vertex_count <= '0;
    end else if (clear) begin
      overflow     <= 1'b0;
      vertex_count <= '0;
    end else if (complete) begin
      if (push_rdy) vertex_count <= vertex_count + 16'd1;
      else          overflow     <= 1'b1;
    end
  end
endmodule

// File: doc/vertex_collector.md
VERTEX_COLLECTOR -- requirements
Module: vertex_collector

Interface
Parameters:
REQ-001 The block SHALL have parameter M, default 11, giving the signed component width and matching the vertex processor output width.
REQ-002 The block SHALL have parameter DEPTH, default 8, giving the vertex FIFO depth in whole vertices; legal values are powers of two, 2 to 64.
Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port in_component, input, signed [M-1:0]: scalar component from the vertex processor output_vertex.
REQ-006 The block SHALL have port in_component_valid, input, 1 bit: in_component is valid this cycle; no backpressure toward the source.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous flush of assembly, FIFO and status.
REQ-008 The block SHALL have ports out_x, out_y, out_z and out_w, each output, signed [M-1:0]: head-of-FIFO vertex components.
REQ-009 The block SHALL have port out_valid, output, 1 bit: a vertex is presented on out_x/out_y/out_z/out_w.
REQ-010 The block SHALL have port out_ready, input, 1 bit: downstream accepts the vertex when out_valid is also high.
REQ-011 The block SHALL have port level, output, [$clog2(DEPTH):0]: number of vertices stored.
REQ-012 The block SHALL have port overflow, output, 1 bit: sticky flag, set when a completed vertex is dropped.
REQ-013 The block SHALL have port vertex_count, output, [15:0]: number of vertices accepted into the FIFO; wraps at 65535 to 0.

Function
REQ-014 Component index SHALL be a 2-bit counter, 0..3, mapping to x, y, z, w in that order; it advances only on a clk edge with in_component_valid=1 and clear=0.
REQ-015 Components 0..2 SHALL be captured into assembly registers; the component at index 3 SHALL complete the vertex and index SHALL wrap to 0.
REQ-016 On completion, {x, y, z, in_component} SHALL be pushed into the FIFO in the same edge, with no sign or width change (bit-exact M-bit signed values).
REQ-017 Push latency: if w is captured at edge k, out_valid SHALL be high after edge k when the FIFO was empty before it (1 cycle, first-word fall-through).
REQ-018 FIFO: out_valid = (level != 0); out_x/out_y/out_z/out_w SHALL show the oldest vertex; pop on an edge with out_valid=1 and out_ready=1.
REQ-019 Outputs SHALL hold stable while out_valid=1 and out_ready=0.
REQ-020 Full FIFO (level=DEPTH) plus completion with no pop in the same edge: the vertex SHALL be dropped, overflow set to 1, level and vertex_count unchanged, and the index still wraps to 0.
REQ-021 Full FIFO plus completion plus pop in the same edge: the push SHALL be accepted, level stays DEPTH, and overflow is not set.
REQ-022 Empty FIFO plus completion: pop SHALL NOT occur in that edge, even if out_ready=1.
REQ-023 Simultaneous push and pop with 0 < level < DEPTH: level SHALL be unchanged.
REQ-024 vertex_count SHALL increment by 1 on each accepted push.
REQ-025 clear=1 at an edge SHALL do the following: index to 0, level to 0, overflow to 0, vertex_count to 0, and assembly registers to 0. Any in_component_valid and any pop in that edge SHALL be ignored.
REQ-026 Read and write pointers SHALL wrap modulo DEPTH; level SHALL be derived so that full and empty are unambiguous.
REQ-027 overflow SHALL remain 1 until clear or reset.

Reset
REQ-028 While reset=1, asynchronously: index=0, level=0, out_valid=0, overflow=0, vertex_count=0, out_x/out_y/out_z/out_w=0, and assembly registers=0.
REQ-029 FIFO storage contents need not be reset; out_* SHALL read 0 whenever out_valid=0.
REQ-030 Reset asserted mid-vertex (e.g. after 2 components) SHALL discard the partial vertex; the first valid component after release is x.

Verification
REQ-031 Scenario: reset release, out_ready=1, stream 10,-20,30,128 on consecutive cycles -> one cycle after 128 is captured, out_valid=1 with x=10, y=-20, z=30, w=128; vertex_count=1.
REQ-032 Scenario: out_ready=0, stream 9 vertices with DEPTH=8 -> level=8, overflow=1, vertex_count=8; the 9th vertex is absent on drain and the first 8 emerge in order.
REQ-033 Scenario: FIFO full, out_ready=1 in the same cycle the 9th vertex completes -> level stays 8, overflow=0, vertex_count=9.
REQ-034 Scenario: valid gaps (components -1024,1023,0,-1 spread over 10 cycles with random idle cycles) -> one vertex (-1024,1023,0,-1), exact sign preserved.
REQ-035 Scenario: 3 components, then clear=1 together with a valid component, then 4 components 1,2,3,4 -> single vertex (1,2,3,4), level=1, overflow=0.
REQ-036 Scenario: reset pulse after 2 components with 3 vertices buffered -> out_valid=0 immediately (asynchronous), level=0; next 4 components form a fresh vertex.
